// File: rtl/trap_unit.sv
// Machine-mode trap sequencer: arbitrates exceptions, interrupts and MRET, emits the
// one-cycle CSR update bundle and a held PC redirect with ready/valid handshake.
module trap_unit #(
    parameter int unsigned XLEN        = 64,
    parameter bit          VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_in,
    input  logic            exc_valid_in,
    input  logic [5:0]      exc_cause_in,
    input  logic [XLEN-1:0] exc_tval_in,
    input  logic [XLEN-1:0] exc_pc_in,
    input  logic            mret_in,
    input  logic            int_ok_in,
    input  logic [XLEN-1:0] next_pc_in,
    input  logic [2:0]      mip_in,
    input  logic [2:0]      mie_in,
    input  logic            mstatus_mie_in,
    input  logic [XLEN-1:0] mtvec_base_in,
    input  logic            mtvec_mode_in,
    input  logic [XLEN-1:0] mepc_in,
    output logic            trap_we_out,
    output logic [XLEN-1:0] mepc_out,
    output logic [XLEN-1:0] mcause_out,
    output logic [XLEN-1:0] mtval_out,
    output logic            mstatus_trap_out,
    output logic            mstatus_mret_out,
    output logic            flush_out,
    output logic            busy_out,
    output logic            redirect_valid_out,
    output logic [XLEN-1:0] redirect_pc_out,
    input  logic            redirect_ready_in
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAP,
        S_MRET,
        S_REDIR
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] target_q, target_d;

    logic [2:0]      pend;
    logic            int_take;
    logic [5:0]      int_code;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] vec_target;
    logic            idle_ok;
    logic            acc_exc, acc_mret, acc_int;

    // Event arbitration; reset gates acceptance so flush_out is 0 during reset.
    always_comb begin
        pend     = mip_in & mie_in;
        int_take = int_ok_in & mstatus_mie_in & (|pend);
        if (pend[2]) begin
            int_code = 6'd11;
        end else if (pend[0]) begin
            int_code = 6'd3;
        end else begin
            int_code = 6'd7;
        end
        base       = {mtvec_base_in[XLEN-1:2], 2'b00};
        vec_target = base + {{(XLEN-8){1'b0}}, int_code, 2'b00};
        idle_ok    = (state_q == S_IDLE) & ~stall_in & ~reset;
        acc_exc    = idle_ok & exc_valid_in;
        acc_mret   = idle_ok & ~exc_valid_in & mret_in;
        acc_int    = idle_ok & ~exc_valid_in & ~mret_in & int_take;
    end

    always_comb begin
        state_d   = state_q;
        mepc_d    = mepc_q;
        mcause_d  = mcause_q;
        mtval_d   = mtval_q;
        target_d  = target_q;
        flush_out = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (acc_exc) begin
                    state_d   = S_TRAP;
                    mepc_d    = {exc_pc_in[XLEN-1:2], 2'b00};
                    mcause_d  = {{(XLEN-6){1'b0}}, exc_cause_in};
                    mtval_d   = exc_tval_in;
                    target_d  = base;
                    flush_out = 1'b1;
                end else if (acc_mret) begin
                    state_d   = S_MRET;
                    target_d  = mepc_in;
                    flush_out = 1'b1;
                end else if (acc_int) begin
                    state_d   = S_TRAP;
                    mepc_d    = {next_pc_in[XLEN-1:2], 2'b00};
                    mcause_d  = {1'b1, {(XLEN-7){1'b0}}, int_code};
                    mtval_d   = '0;
                    target_d  = (VECTORED_EN && mtvec_mode_in) ? vec_target : base;
                    flush_out = 1'b1;
                end
            end
            S_TRAP:  state_d = S_REDIR;
            S_MRET:  state_d = S_REDIR;
            S_REDIR: begin
                if (redirect_ready_in) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mtval_q  <= mtval_d;
            target_q <= target_d;
        end
    end

    assign trap_we_out        = (state_q == S_TRAP);
    assign mstatus_trap_out   = (state_q == S_TRAP);
    assign mstatus_mret_out   = (state_q == S_MRET);
    assign redirect_valid_out = (state_q == S_REDIR);
    assign busy_out           = (state_q != S_IDLE);
    assign mepc_out           = mepc_q;
    assign mcause_out         = mcause_q;
    assign mtval_out          = mtval_q;
    assign redirect_pc_out    = target_q;

endmodule
